// File: rtl/regs_sb.sv
// General-purpose register file with byte-lane writes, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regs_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   reg_Rd_addr_A,
  input  logic [AW-1:0]   reg_Rt_addr_B,
  input  logic [AW-1:0]   reg_Wt_addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic [DW-1:0]   rdata_A,
  output logic [DW-1:0]   rdata_B,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr,
  output logic            busy_A,
  output logic            busy_B
);

  localparam int DEPTH = 1 << AW;
  localparam int NB    = DW / 8;
  localparam bit Z0    = (ZERO_R0 != 0);
  localparam bit BYP   = (BYPASS != 0);

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic             w_wr_ok;
  logic             w_set_ok;
  logic [DW-1:0]    w_merged;
  logic [DEPTH-1:0] w_busy_nxt;

  assign w_wr_ok  = we && !(Z0 && (reg_Wt_addr == '0));
  assign w_set_ok = busy_set && !(Z0 && (busy_addr == '0));

  // Byte merge: exactly the value the target register holds after the edge.
  always_comb begin
    w_merged = r_regs[reg_Wt_addr];
    for (int i = 0; i < NB; i++) begin
      if (wstrb[i]) w_merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Set is applied after clear so a same-address collision leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we) w_busy_nxt[reg_Wt_addr] = 1'b0;
    if (w_set_ok) w_busy_nxt[busy_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_regs[reg_Wt_addr] <= w_merged;
      r_busy <= w_busy_nxt;
    end
  end

  function automatic logic [DW-1:0] read_data(input logic [AW-1:0] addr);
    if (Z0 && (addr == '0))                        return '0;
    else if (BYP && w_wr_ok && (reg_Wt_addr == addr)) return w_merged;
    else                                           return r_regs[addr];
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] addr);
    if (Z0 && (addr == '0)) return 1'b0;
    else if (BYP && we && (reg_Wt_addr == addr) && !(w_set_ok && (busy_addr == addr)))
      return 1'b0;
    else return r_busy[addr];
  endfunction

  always_comb begin
    rdata_A = read_data(reg_Rd_addr_A);
    rdata_B = read_data(reg_Rt_addr_B);
    busy_A  = read_busy(reg_Rd_addr_A);
    busy_B  = read_busy(reg_Rt_addr_B);
  end

endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: one bypassing and one non-bypassing instance
// share stimulus; a vector table plus a short busy-latency sequence.
module tb_regs_sb;

  logic        clk = 1'b0;
  logic        rst, we, busy_set;
  logic [4:0]  ra, rb, wa, baddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] y_a, y_b, n_a, n_b;
  logic        y_ba, y_bb, n_ba, n_bb;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regs_sb #(.DW(32), .AW(5), .ZERO_R0(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .we(we),
    .reg_Rd_addr_A(ra), .reg_Rt_addr_B(rb), .reg_Wt_addr(wa),
    .wdata(wdata), .wstrb(wstrb),
    .rdata_A(y_a), .rdata_B(y_b),
    .busy_set(busy_set), .busy_addr(baddr),
    .busy_A(y_ba), .busy_B(y_bb)
  );

  regs_sb #(.DW(32), .AW(5), .ZERO_R0(1), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .we(we),
    .reg_Rd_addr_A(ra), .reg_Rt_addr_B(rb), .reg_Wt_addr(wa),
    .wdata(wdata), .wstrb(wstrb),
    .rdata_A(n_a), .rdata_B(n_b),
    .busy_set(busy_set), .busy_addr(baddr),
    .busy_A(n_ba), .busy_B(n_bb)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        bs;
    logic [4:0]  baddr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        chk;
    logic [31:0] ea;   // bypass instance rdata_A
    logic [31:0] eb;   // bypass instance rdata_B
    logic [31:0] ena;  // non-bypass instance rdata_A
    logic [31:0] enb;  // non-bypass instance rdata_B
    logic        eba;  // bypass instance busy_A
    logic        ebb;  // bypass instance busy_B
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic b, input logic [4:0] bad,
                              input logic [4:0] x, input logic [4:0] y,
                              input logic c, input logic [31:0] ea,
                              input logic [31:0] eb, input logic [31:0] ena,
                              input logic [31:0] enb, input logic eba,
                              input logic ebb);
    vec_t v;
    v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ws = s; v.bs = b; v.baddr = bad;
    v.ra = x; v.rb = y; v.chk = c; v.ea = ea; v.eb = eb; v.ena = ena; v.enb = enb;
    v.eba = eba; v.ebb = ebb;
    return v;
  endfunction

  task automatic check(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; we = v.we; wa = v.wa; wdata = v.wd; wstrb = v.ws;
    busy_set = v.bs; baddr = v.baddr; ra = v.ra; rb = v.rb;
  endtask

  initial begin
    //        rst we wa  wdata         ws   bs ba  ra  rb  chk ea            eb            ena           enb           eba ebb
    tv[0]  = mk(1, 0, 0,  32'h0,        4'h0, 0, 0,  0,  0,  0, 0,            0,            0,            0,            0, 0);
    tv[1]  = mk(0, 1, 5,  32'hA5A5A5A5, 4'hF, 0, 0,  1,  6,  1, 0,            0,            0,            0,            0, 0);
    tv[2]  = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  5,  6,  1, 32'hA5A5A5A5, 0,            32'hA5A5A5A5, 0,            0, 0);
    tv[3]  = mk(0, 1, 0,  32'hAAAA5555, 4'hF, 0, 0,  0,  5,  1, 0,            32'hA5A5A5A5, 0,            32'hA5A5A5A5, 0, 0);
    tv[4]  = mk(0, 1, 6,  32'h11223344, 4'hF, 0, 0,  0,  6,  1, 0,            32'h11223344, 0,            0,            0, 0);
    tv[5]  = mk(0, 1, 6,  32'hFFFFFFFF, 4'h5, 0, 0,  6,  6,  1, 32'h11FF33FF, 32'h11FF33FF, 32'h11223344, 32'h11223344, 0, 0);
    tv[6]  = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  6,  5,  1, 32'h11FF33FF, 32'hA5A5A5A5, 32'h11FF33FF, 32'hA5A5A5A5, 0, 0);
    tv[7]  = mk(0, 1, 7,  32'hDEADBEEF, 4'hF, 0, 0,  7,  7,  1, 32'hDEADBEEF, 32'hDEADBEEF, 0,            0,            0, 0);
    tv[8]  = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  7,  0,  1, 32'hDEADBEEF, 0,            32'hDEADBEEF, 0,            0, 0);
    tv[9]  = mk(0, 0, 0,  32'h0,        4'h0, 1, 9,  9,  9,  1, 0,            0,            0,            0,            0, 0);
    tv[10] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  0,  9,  1, 0,            0,            0,            0,            0, 1);
    tv[11] = mk(0, 1, 9,  32'hCAFEF00D, 4'h0, 0, 0,  9,  9,  1, 0,            0,            0,            0,            0, 0);
    tv[12] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  9,  9,  1, 0,            0,            0,            0,            0, 0);
    tv[13] = mk(0, 0, 0,  32'h0,        4'h0, 1, 3,  3,  3,  1, 0,            0,            0,            0,            0, 0);
    tv[14] = mk(0, 1, 3,  32'h00000033, 4'hF, 1, 3,  3,  4,  1, 32'h33,       0,            0,            0,            1, 0);
    tv[15] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  3,  3,  1, 32'h33,       32'h33,       32'h33,       32'h33,       1, 1);
    tv[16] = mk(0, 0, 0,  32'h0,        4'h0, 1, 0,  3,  0,  1, 32'h33,       0,            32'h33,       0,            1, 0);
    tv[17] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  0,  0,  1, 0,            0,            0,            0,            0, 0);
    tv[18] = mk(0, 1, 3,  32'h00000044, 4'h1, 1, 10, 3,  10, 1, 32'h44,       0,            32'h33,       0,            0, 0);
    tv[19] = mk(0, 0, 0,  32'h0,        4'h0, 1, 9,  3,  10, 1, 32'h44,       0,            32'h44,       0,            0, 1);
    tv[20] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  5,  6,  1, 32'hA5A5A5A5, 32'h11FF33FF, 32'hA5A5A5A5, 32'h11FF33FF, 0, 0);
    tv[21] = mk(1, 1, 5,  32'h12345678, 4'hF, 1, 11, 9,  10, 1, 0,            0,            0,            0,            1, 1);
    tv[22] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  5,  6,  1, 0,            0,            0,            0,            0, 0);
    tv[23] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  9,  10, 1, 0,            0,            0,            0,            0, 0);
    tv[24] = mk(0, 0, 0,  32'h0,        4'h0, 0, 0,  11, 3,  1, 0,            0,            0,            0,            0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      if (tv[i].chk) begin
        check("rdata_A_byp",  i, y_a,  tv[i].ea);
        check("rdata_B_byp",  i, y_b,  tv[i].eb);
        check("rdata_A_nob",  i, n_a,  tv[i].ena);
        check("rdata_B_nob",  i, n_b,  tv[i].enb);
        check("busy_A_byp",   i, {31'd0, y_ba}, {31'd0, tv[i].eba});
        check("busy_B_byp",   i, {31'd0, y_bb}, {31'd0, tv[i].ebb});
      end
    end

    // Busy clear latency: same cycle with bypass, next cycle without.
    @(negedge clk);
    rst = 0; we = 0; wa = 0; wdata = 0; wstrb = 0;
    busy_set = 1; baddr = 12; ra = 12; rb = 12;
    @(negedge clk);
    busy_set = 0; we = 1; wa = 12; wdata = 32'h0BADF00D; wstrb = 4'h0;
    #1;
    check("seq_busy_A_byp_clr", 100, {31'd0, y_ba}, 32'd0);
    check("seq_busy_A_nob_clr", 100, {31'd0, n_ba}, 32'd1);
    check("seq_rdata_A_nob",    100, n_a, 32'd0);
    @(negedge clk);
    we = 0;
    #1;
    check("seq_busy_A_byp_after", 101, {31'd0, y_ba}, 32'd0);
    check("seq_busy_B_nob_after", 101, {31'd0, n_bb}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
